// File: rtl/uart_receiver_controller.sv
// Decodes received UART frames into register-file writes/reads and ALU commands.
// Outputs are Mealy so a strobe appears in the same cycle its frame becomes valid.
module uart_receiver_controller #(
    parameter int unsigned DATA_WIDTH          = 8,
    parameter int unsigned REGISTER_FILE_DEPTH = 16,
    localparam int unsigned AW                 = $clog2(REGISTER_FILE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  parallel_data_valid_synchronized,
    input  logic [DATA_WIDTH-1:0] parallel_data_synchronized,
    output logic [3:0]            ALU_function,
    output logic                  ALU_enable,
    output logic                  ALU_clk_enable,
    output logic [AW-1:0]         address,
    output logic                  write_enable,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  read_enable
);

    localparam logic [DATA_WIDTH-1:0] CmdWrite   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CmdRead    = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CmdAluOps  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CmdAluNoOp = DATA_WIDTH'(8'hDD);

    typedef enum logic [2:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StAluA,
        StAluB,
        StAluFunc
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            valid_prev_q;
    logic            frame_open_q, frame_open_d;
    logic            valid;
    logic            new_frame;
    logic            frame_end;
    logic            frame_active;

    assign valid      = parallel_data_valid_synchronized;
    assign new_frame  = valid & ~valid_prev_q;
    assign frame_end  = ~valid & valid_prev_q;
    // The frame that moved us into a terminal state may still be held; only the next
    // frame (opened by a rising edge inside the state) is acted on and ends the command.
    assign frame_active = valid & (new_frame | frame_open_q);

    assign write_data     = parallel_data_synchronized;
    assign ALU_clk_enable = ALU_enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            valid_prev_q <= 1'b0;
            frame_open_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            valid_prev_q <= valid;
            frame_open_q <= frame_open_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        frame_open_d = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        ALU_enable   = 1'b0;
        ALU_function = 4'h0;
        address      = '0;

        if (enable && !reset) begin
            case (state_q)
                StIdle: begin
                    if (new_frame) begin
                        case (parallel_data_synchronized)
                            CmdWrite:   state_d = StWrAddr;
                            CmdRead:    state_d = StRdAddr;
                            CmdAluOps:  state_d = StAluA;
                            CmdAluNoOp: state_d = StAluFunc;
                            default:    state_d = StIdle;
                        endcase
                    end
                end
                StWrAddr: begin
                    if (new_frame) begin
                        addr_d  = parallel_data_synchronized[AW-1:0];
                        state_d = StWrData;
                    end
                end
                StWrData: begin
                    frame_open_d = frame_active;
                    if (frame_active) begin
                        write_enable = 1'b1;
                        address      = addr_q;
                    end
                    if (frame_end && frame_open_q) state_d = StIdle;
                end
                StRdAddr: begin
                    frame_open_d = frame_active;
                    if (frame_active) begin
                        read_enable = 1'b1;
                        address     = parallel_data_synchronized[AW-1:0];
                    end
                    if (frame_end && frame_open_q) state_d = StIdle;
                end
                StAluA: begin
                    if (new_frame) begin
                        write_enable = 1'b1;
                        address      = '0;
                        state_d      = StAluB;
                    end
                end
                StAluB: begin
                    if (new_frame) begin
                        write_enable = 1'b1;
                        address      = AW'(1);
                        state_d      = StAluFunc;
                    end
                end
                StAluFunc: begin
                    frame_open_d = frame_active;
                    if (frame_active) begin
                        ALU_enable   = 1'b1;
                        ALU_function = parallel_data_synchronized[3:0];
                    end
                    if (frame_end && frame_open_q) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else begin
            state_d = StIdle;
        end
    end

endmodule

// File: tb/tb_uart_receiver_controller.sv
// Scoreboard bench: stimulus queues expected strobe vectors, a negedge monitor
// pops one for every cycle the DUT asserts any strobe.
module tb_uart_receiver_controller;

    logic       reference_clk_tb;
    logic       reset;
    logic       enable;
    logic       valid;
    logic [7:0] data;
    logic [3:0] alu_function;
    logic       alu_enable;
    logic       alu_clk_enable;
    logic [3:0] address;
    logic       write_enable;
    logic [7:0] write_data;
    logic       read_enable;

    int checks   = 0;
    int failures = 0;
    logic       mon_on = 1'b0;
    logic [19:0] exp_q[$];

    uart_receiver_controller #(
        .DATA_WIDTH          (8),
        .REGISTER_FILE_DEPTH (16)
    ) dut (
        .clk                              (reference_clk_tb),
        .reset                            (reset),
        .enable                           (enable),
        .parallel_data_valid_synchronized (valid),
        .parallel_data_synchronized       (data),
        .ALU_function                     (alu_function),
        .ALU_enable                       (alu_enable),
        .ALU_clk_enable                   (alu_clk_enable),
        .address                          (address),
        .write_enable                     (write_enable),
        .write_data                       (write_data),
        .read_enable                      (read_enable)
    );

    initial reference_clk_tb = 1'b0;
    always #5 reference_clk_tb = ~reference_clk_tb;

    function automatic logic [19:0] vec(logic we, logic re, logic ae, logic ace,
                                        logic [3:0] ad, logic [3:0] fn, logic [7:0] wd);
        return {we, re, ae, ace, ad, fn, wd};
    endfunction

    function automatic logic [19:0] actual();
        return {write_enable, read_enable, alu_enable, alu_clk_enable,
                address, alu_function, write_data};
    endfunction

    // Monitor: every strobing cycle must match the next queued expectation.
    always @(negedge reference_clk_tb) begin
        if (mon_on && (write_enable || read_enable || alu_enable || alu_clk_enable)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe got=%05h required=none", actual());
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                if (actual() !== e) begin
                    failures++;
                    $display("FAIL strobe got=%05h required=%05h", actual(), e);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input int n);
        valid = v;
        data  = d;
        repeat (n) @(posedge reference_clk_tb);
        #1;
    endtask

    task automatic frame(input logic [7:0] d, input int hold);
        drive(1'b1, d, hold);
        drive(1'b0, d, 2);
    endtask

    task automatic expect_n(input logic [19:0] e, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Direct check at the next negedge that no strobe is active.
    task automatic check_quiet(input string name);
        @(negedge reference_clk_tb);
        checks++;
        if (actual() !== vec(0, 0, 0, 0, 4'h0, 4'h0, data)) begin
            failures++;
            $display("FAIL %s got=%05h required=%05h", name, actual(),
                     vec(0, 0, 0, 0, 4'h0, 4'h0, data));
        end
        @(posedge reference_clk_tb);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        valid  = 1'b1;
        data   = 8'hDD;
        check_quiet("reset_outputs");
        drive(1'b0, 8'h00, 2);
        reset  = 1'b0;
        mon_on = 1'b1;
        drive(1'b0, 8'h00, 2);

        // Write: AA, 0D, CF
        frame(8'hAA, 2);
        frame(8'h0D, 3);
        expect_n(vec(1, 0, 0, 0, 4'hD, 4'h0, 8'hCF), 3);
        frame(8'hCF, 3);
        valid = 1'b1;
        check_quiet("write_back_to_idle");
        drive(1'b0, 8'hCF, 2);

        // Read: BB, 08
        frame(8'hBB, 1);
        expect_n(vec(0, 1, 0, 0, 4'h8, 4'h0, 8'h08), 2);
        frame(8'h08, 2);

        // ALU with operands: CC, 09, 0A, 04
        frame(8'hCC, 1);
        expect_n(vec(1, 0, 0, 0, 4'h0, 4'h0, 8'h09), 1);
        frame(8'h09, 4);
        expect_n(vec(1, 0, 0, 0, 4'h1, 4'h0, 8'h0A), 1);
        frame(8'h0A, 2);
        expect_n(vec(0, 0, 1, 1, 4'h0, 4'h4, 8'h04), 2);
        frame(8'h04, 2);

        // ALU without operands, upper bits ignored on opcode
        frame(8'hDD, 2);
        expect_n(vec(0, 0, 1, 1, 4'h0, 4'hE, 8'h0E), 3);
        frame(8'h0E, 3);
        frame(8'hDD, 1);
        expect_n(vec(0, 0, 1, 1, 4'h0, 4'h7, 8'hA7), 1);
        frame(8'hA7, 1);

        // Unknown command ignored, then read with upper address bits ignored
        valid = 1'b1;
        data  = 8'h55;
        check_quiet("ignore_0x55");
        frame(8'h55, 4);
        frame(8'hBB, 1);
        expect_n(vec(0, 1, 0, 0, 4'h3, 4'h0, 8'hF3), 1);
        frame(8'hF3, 1);

        // Long-held frames each cause a single transition
        frame(8'hAA, 10);
        frame(8'h02, 6);
        expect_n(vec(1, 0, 0, 0, 4'h2, 4'h0, 8'h11), 2);
        frame(8'h11, 2);

        // Reset mid-command discards the pending write
        frame(8'hAA, 1);
        reset = 1'b1;
        drive(1'b0, 8'h00, 1);
        reset = 1'b0;
        frame(8'hBB, 1);
        expect_n(vec(0, 1, 0, 0, 4'h3, 4'h0, 8'h03), 1);
        frame(8'h03, 1);

        // enable low forces idle
        frame(8'hAA, 1);
        enable = 1'b0;
        drive(1'b0, 8'h00, 1);
        enable = 1'b1;
        frame(8'hBB, 1);
        expect_n(vec(0, 1, 0, 0, 4'h3, 4'h0, 8'h03), 1);
        frame(8'h03, 1);

        // Disabled mid-ALU: no strobes; valid_prev keeps tracking while disabled
        frame(8'hDD, 1);
        enable = 1'b0;
        valid  = 1'b1;
        data   = 8'h05;
        check_quiet("disabled_alu_quiet");
        drive(1'b1, 8'hBB, 2);
        enable = 1'b1;
        drive(1'b1, 8'hBB, 2);
        drive(1'b0, 8'hBB, 2);
        frame(8'h07, 2);
        frame(8'hBB, 1);
        expect_n(vec(0, 1, 0, 0, 4'h9, 4'h0, 8'h09), 1);
        frame(8'h09, 1);

        drive(1'b0, 8'h00, 4);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_strobes got=%0d_left required=0_left", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver_controller.md
UART_RECEIVER_CONTROLLER -- requirements
Module: uart_receiver_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of received frames and write_data SHALL be as stated.
REQ-002 Parameter REGISTER_FILE_DEPTH, default 16, register-file depth; address width AW = clog2(REGISTER_FILE_DEPTH) SHALL be as stated.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  block enable; low SHALL force idle behaviour.
REQ-006 parallel_data_valid_synchronized  input  1  frame-valid level, may stay high for many cycles.
REQ-007 parallel_data_synchronized  input  DATA_WIDTH  received frame byte.
REQ-008 ALU_function  output  4  ALU opcode.
REQ-009 ALU_enable  output  1  ALU operation strobe.
REQ-010 ALU_clk_enable  output  1  ALU clock-gate enable, always equal to ALU_enable.
REQ-011 address  output  AW  register-file address.
REQ-012 write_enable  output  1  register-file write strobe.
REQ-013 write_data  output  DATA_WIDTH  register-file write data.
REQ-014 read_enable  output  1  register-file read strobe.

Function
REQ-015 Register valid_prev SHALL hold the previous-cycle value of parallel_data_valid_synchronized; new frame = valid & ~valid_prev; frame end = ~valid & valid_prev.
REQ-016 FSM states SHALL be: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC.
REQ-017 IDLE, on new frame: 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->ALU_A, 0xDD->ALU_FUNC; any other byte SHALL be ignored, staying in IDLE.
REQ-018 WR_ADDR, on new frame: store byte[AW-1:0] into internal addr_reg and go to WR_DATA.
REQ-019 ALU_A, on new frame: go to ALU_B; ALU_B, on new frame: go to ALU_FUNC.
REQ-020 WR_DATA, RD_ADDR and ALU_FUNC SHALL return to IDLE on frame end.
REQ-021 Outputs SHALL be combinational (Mealy) from state, valid and data, so a strobe is visible in the same cycle valid rises.
REQ-022 write_data SHALL equal parallel_data_synchronized at all times.
REQ-023 WR_DATA with valid high: write_enable=1 and address=addr_reg.
REQ-024 RD_ADDR with valid high: read_enable=1 and address=byte[AW-1:0].
REQ-025 ALU_A on new frame: write_enable=1 and address=0, for one cycle; ALU_B on new frame: write_enable=1 and address=1, for one cycle.
REQ-026 ALU_FUNC with valid high: ALU_enable=ALU_clk_enable=1 and ALU_function=byte[3:0].
REQ-027 In every other condition: all strobes=0, ALU_function=0, address=0.
REQ-028 Upper data bits beyond the AW address bits or the 4 opcode bits SHALL be ignored.
REQ-029 enable low: FSM SHALL be forced to IDLE and all strobes SHALL be 0; valid_prev SHALL still track the input.

Reset
REQ-030 reset high at a clock edge: state=IDLE, addr_reg=0, valid_prev=0; all strobes low, address=0, ALU_function=0.
REQ-031 reset SHALL take priority over enable and valid, including mid-command; the partial command SHALL be discarded.

Verification
REQ-032 Write: frames 0xAA, 0x0D, 0xCF -> while 0xCF is valid: write_enable=1, address=0xD, write_data=0xCF; after valid falls: IDLE, write_enable=0.
REQ-033 Read: frames 0xBB, 0x08 -> while 0x08 is valid: read_enable=1, address=0x8; write_enable=0.
REQ-034 ALU with operands: frames 0xCC, 0x09, 0x0A, 0x04 -> one-cycle write of 0x09 to address 0; one-cycle write of 0x0A to address 1; then ALU_enable=ALU_clk_enable=1 and ALU_function=0x4 while 0x04 is valid.
REQ-035 ALU without operands: frames 0xDD, 0x0E -> ALU_enable=ALU_clk_enable=1, ALU_function=0xE while valid; no write_enable.
REQ-036 Robustness: frame 0x55 in IDLE is ignored; valid held high across many cycles yields exactly one transition; reset asserted after 0xAA returns to IDLE, so a following 0xBB, 0x03 asserts read_enable with address=0x3.
